// File: rtl/pair_serializer.sv
// pair_serializer: accepts an (in0, in1) word pair over a val/rdy handshake
// and emits the two words one per transfer, in0 first, then in1. The select
// driving the downstream 2:1 word mux is exposed on `sel`. Completed pairs
// are counted modulo 2^CBITS.
module pair_serializer #(
   parameter int NBITS = 8,
   parameter int CBITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in0,
   input  logic [NBITS-1:0] in1,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [NBITS-1:0] out,
   output logic             sel,
   output logic [CBITS-1:0] count
);

   // 2'b11 is deliberately unused; the next-state default steers it to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SEND0 = 2'b01,
      SEND1 = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             pair_done;
   logic [NBITS-1:0] reg0;
   logic [NBITS-1:0] reg1;

   // State register; reset drops any pair in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking (<=) so every register
         // samples pre-edge values regardless of statement order.
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake outputs. No combinational path from any
   // input to any output except out_rdy -> in_rdy while in SEND1.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves
      // it unassigned and no latch is inferred.
      state_nxt = IDLE;
      in_rdy    = 1'b0;
      out_val   = 1'b0;
      sel       = 1'b0;
      load      = 1'b0;
      pair_done = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_val) begin
               load      = 1'b1;
               state_nxt = SEND0;
            end
         end
         SEND0: begin
            out_val   = 1'b1;
            state_nxt = out_rdy ? SEND1 : SEND0;
         end
         SEND1: begin
            out_val = 1'b1;
            sel     = 1'b1;
            in_rdy  = out_rdy;
            if (out_rdy) begin
               pair_done = 1'b1;
               if (in_val) begin
                  // Back-to-back: the next pair loads as the last word leaves.
                  load      = 1'b1;
                  state_nxt = SEND0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt = SEND1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pair holding registers; written only when a pair is accepted, so they
   // stay stable while the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data registers are reset on purpose: `out` must read
         // zero while reset is asserted, not stale data.
         reg0 <= '0;
         reg1 <= '0;
      end else if (load) begin
         reg0 <= in0;
         reg1 <= in1;
      end
   end

   // Completed-pair counter, wraps naturally at 2^CBITS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (pair_done) begin
         count <= count + CBITS'(1);
      end
   end

   assign out = sel ? reg1 : reg0;

endmodule

// File: tb/tb_pair_serializer.sv
// Directed testbench for pair_serializer. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge. A second
// instance with CBITS=2 shares all inputs and exercises counter wrap.
module tb_pair_serializer;

   logic       clk;
   logic       rst;
   logic       in_val;
   logic       in_rdy;
   logic [7:0] in0;
   logic [7:0] in1;
   logic       out_val;
   logic       out_rdy;
   logic [7:0] out;
   logic       sel;
   logic [7:0] count;

   logic       in_rdy2;
   logic       out_val2;
   logic [7:0] out2;
   logic       sel2;
   logic [1:0] count2;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;

   pair_serializer #(.NBITS(8), .CBITS(8)) dut (
      .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy),
      .in0(in0), .in1(in1), .out_val(out_val), .out_rdy(out_rdy),
      .out(out), .sel(sel), .count(count)
   );

   pair_serializer #(.NBITS(8), .CBITS(2)) dut2 (
      .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy2),
      .in0(in0), .in1(in1), .out_val(out_val2), .out_rdy(out_rdy),
      .out(out2), .sel(sel2), .count(count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {in_rdy, out_val, sel, out} packed for compact comparisons.
   function automatic logic [10:0] pack(logic r, logic v, logic s, logic [7:0] o);
      return {r, v, s, o};
   endfunction

   task automatic test_reset;
      rst = 1'b1; in_val = 1'b0; out_rdy = 1'b0; in0 = 8'h00; in1 = 8'h00;
      #1;
      checks++;
      if (pack(in_rdy, out_val, sel, out) !== pack(1'b1, 1'b0, 1'b0, 8'h00) || count !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: got rdy/val/sel/out=%h count=%0d, want %h count=0",
                  pack(in_rdy, out_val, sel, out), count, pack(1'b1, 1'b0, 1'b0, 8'h00));
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset_mid_pair;
      @(negedge clk); in_val = 1'b1; in0 = 8'hAB; in1 = 8'hCD; out_rdy = 1'b0;
      @(negedge clk); in_val = 1'b0;
      #1;
      checks++;
      if (pack(in_rdy, out_val, sel, out) !== pack(1'b0, 1'b1, 1'b0, 8'hAB)) begin
         errors++;
         $display("FAIL midreset_send0: got %h want %h", pack(in_rdy, out_val, sel, out),
                  pack(1'b0, 1'b1, 1'b0, 8'hAB));
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (pack(in_rdy, out_val, sel, out) !== pack(1'b1, 1'b0, 1'b0, 8'h00) || count !== 8'd0) begin
         errors++;
         $display("FAIL midreset_async: got %h count=%0d want %h count=0",
                  pack(in_rdy, out_val, sel, out), count, pack(1'b1, 1'b0, 1'b0, 8'h00));
      end
      @(negedge clk); rst = 1'b0;
      exp_count = 0;
   endtask

   task automatic test_single_pair;
      @(negedge clk); in_val = 1'b1; in0 = 8'h12; in1 = 8'h34; out_rdy = 1'b1;
      @(negedge clk); in_val = 1'b0;
      #1;
      checks++;
      if (pack(in_rdy, out_val, sel, out) !== pack(1'b0, 1'b1, 1'b0, 8'h12)) begin
         errors++;
         $display("FAIL single_word0: got %h want %h", pack(in_rdy, out_val, sel, out),
                  pack(1'b0, 1'b1, 1'b0, 8'h12));
      end
      @(negedge clk); #1;
      checks++;
      if (pack(in_rdy, out_val, sel, out) !== pack(1'b1, 1'b1, 1'b1, 8'h34)) begin
         errors++;
         $display("FAIL single_word1: got %h want %h", pack(in_rdy, out_val, sel, out),
                  pack(1'b1, 1'b1, 1'b1, 8'h34));
      end
      exp_count++;
      @(negedge clk); #1;
      checks++;
      if (in_rdy !== 1'b1 || out_val !== 1'b0 || count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL single_idle: got rdy=%b val=%b count=%0d want rdy=1 val=0 count=%0d",
                  in_rdy, out_val, count, exp_count);
      end
   endtask

   task automatic test_stall;
      @(negedge clk); in_val = 1'b1; in0 = 8'h12; in1 = 8'h34; out_rdy = 1'b0;
      repeat (3) begin
         @(negedge clk); in_val = 1'b0; #1;
         checks++;
         if (pack(in_rdy, out_val, sel, out) !== pack(1'b0, 1'b1, 1'b0, 8'h12) ||
             count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL stall_send0: got %h count=%0d want %h count=%0d",
                     pack(in_rdy, out_val, sel, out), count, pack(1'b0, 1'b1, 1'b0, 8'h12), exp_count);
         end
      end
      @(negedge clk); out_rdy = 1'b1;
      repeat (3) begin
         @(negedge clk); out_rdy = 1'b0; #1;
         checks++;
         if (pack(in_rdy, out_val, sel, out) !== pack(1'b0, 1'b1, 1'b1, 8'h34) ||
             count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL stall_send1: got %h count=%0d want %h count=%0d",
                     pack(in_rdy, out_val, sel, out), count, pack(1'b0, 1'b1, 1'b1, 8'h34), exp_count);
         end
      end
      @(negedge clk); out_rdy = 1'b1; #1;
      checks++;
      if (in_rdy !== 1'b1 || count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL stall_rdy_comb: got in_rdy=%b count=%0d want in_rdy=1 count=%0d",
                  in_rdy, count, exp_count);
      end
      exp_count++;
      @(negedge clk); #1;
      checks++;
      if (out_val !== 1'b0 || count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL stall_done: got val=%b count=%0d want val=0 count=%0d",
                  out_val, count, exp_count);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] words [6];
      words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      @(negedge clk); in_val = 1'b1; in0 = words[0]; in1 = words[1]; out_rdy = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k < 5) begin
            in0 = words[2 * ((k + 1) / 2)];
            in1 = words[2 * ((k + 1) / 2) + 1];
         end else begin
            in_val = 1'b0;
         end
         #1;
         checks++;
         if (out_val !== 1'b1 || sel !== 1'((k - 1) % 2) || out !== words[k - 1]) begin
            errors++;
            $display("FAIL b2b_word%0d: got val=%b sel=%b out=%h want val=1 sel=%0d out=%h",
                     k - 1, out_val, sel, out, (k - 1) % 2, words[k - 1]);
         end
      end
      exp_count += 3;
      @(negedge clk); #1;
      checks++;
      if (out_val !== 1'b0 || count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL b2b_count: got val=%b count=%0d want val=0 count=%0d",
                  out_val, count, exp_count);
      end
   endtask

   task automatic test_latched_inputs;
      @(negedge clk); in_val = 1'b1; in0 = 8'hA5; in1 = 8'h5A; out_rdy = 1'b0;
      @(negedge clk); in_val = 1'b0; in0 = 8'hFF; in1 = 8'h00; #1;
      checks++;
      if (out !== 8'hA5 || sel !== 1'b0) begin
         errors++;
         $display("FAIL latch_word0_a: got out=%h sel=%b want out=a5 sel=0", out, sel);
      end
      @(negedge clk); in0 = 8'h11; in1 = 8'h22; out_rdy = 1'b1; #1;
      checks++;
      if (out !== 8'hA5 || sel !== 1'b0) begin
         errors++;
         $display("FAIL latch_word0_b: got out=%h sel=%b want out=a5 sel=0", out, sel);
      end
      @(negedge clk); in1 = 8'h77; #1;
      checks++;
      if (out !== 8'h5A || sel !== 1'b1) begin
         errors++;
         $display("FAIL latch_word1: got out=%h sel=%b want out=5a sel=1", out, sel);
      end
      exp_count++;
      @(negedge clk); #1;
      checks++;
      if (count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL latch_count: got %0d want %0d", count, exp_count);
      end
   endtask

   task automatic test_count_wrap;
      logic [7:0] firsts [5];
      firsts = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      @(negedge clk); rst = 1'b1; in_val = 1'b0; out_rdy = 1'b1;
      #2 rst = 1'b0;
      for (int p = 1; p <= 5; p++) begin
         @(negedge clk); in_val = 1'b1; in0 = firsts[p - 1]; in1 = 8'hEE;
         @(negedge clk); in_val = 1'b0;
         @(negedge clk);
         @(negedge clk); #1;
         checks++;
         if (count2 !== 2'(p % 4) || count !== 8'(p) ||
             pack(in_rdy2, out_val2, sel2, out2) !== pack(1'b1, 1'b0, 1'b0, firsts[p - 1])) begin
            errors++;
            $display("FAIL wrap_pair%0d: got count2=%0d count=%0d state=%h want count2=%0d count=%0d state=%h",
                     p, count2, count, pack(in_rdy2, out_val2, sel2, out2), p % 4, p,
                     pack(1'b1, 1'b0, 1'b0, firsts[p - 1]));
         end
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset;
      test_reset_mid_pair;
      test_single_pair;
      test_stall;
      test_back_to_back;
      test_latched_inputs;
      test_count_wrap;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
